// File: rtl/spi_slave_rx.sv
// spi_slave_rx: SPI responder-side receiver. The three SPI pins are
// oversampled on clk through 2-flop synchronisers. Each MSB-first frame of
// DATA_WIDTH bits is rebuilt and presented on dataOut with a one-cycle
// dataValid strobe. A frame that CS abandons part-way raises a one-cycle
// frameErr strobe.
//
// Output handshake: dataValid and frameErr are single-cycle strobes with no
// ready/back-pressure. A consumer must capture dataOut in the cycle dataValid
// is high. dataOut keeps its value until the next accepted word or reset.
module spi_slave_rx #(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  spi_CS,
  input  logic                  spi_sclk,
  input  logic                  spiData,
  output logic [DATA_WIDTH-1:0] dataOut,
  output logic                  dataValid,
  output logic                  frameErr,
  output logic [CNT_WIDTH-1:0]  bitCount,
  output logic                  busy,
  output logic [1:0]            fsm_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] LAST_BIT = CNT_WIDTH'(DATA_WIDTH - 1);

  // Synchroniser flops. CS and sclk have a third stage for edge detection.
  logic cs_s1, cs_s2, cs_s3;
  logic sclk_s1, sclk_s2, sclk_s3;
  logic data_s1, data_s2;

  logic sclk_rise;
  logic cs_rise;
  logic cs_low;

  state_t state;

  // Partial word. At most DATA_WIDTH-1 bits are held before the final bit
  // completes the word straight into dataOut.
  logic [DATA_WIDTH-2:0] shift;
  logic [DATA_WIDTH-1:0] shift_next;

  // Bring the asynchronous SPI pins into the clk domain (reset to idle levels).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cs_s1   <= 1'b1;
      cs_s2   <= 1'b1;
      cs_s3   <= 1'b1;
      sclk_s1 <= 1'b0;
      sclk_s2 <= 1'b0;
      sclk_s3 <= 1'b0;
      data_s1 <= 1'b0;
      data_s2 <= 1'b0;
    end else begin
      cs_s1   <= spi_CS;
      cs_s2   <= cs_s1;
      cs_s3   <= cs_s2;
      sclk_s1 <= spi_sclk;
      sclk_s2 <= sclk_s1;
      sclk_s3 <= sclk_s2;
      data_s1 <= spiData;
      data_s2 <= data_s1;
    end
  end

  // The data bit has the same synchroniser depth as sclk, so data_s2 is the
  // bit that was on the pin when the sclk rise was captured.
  assign sclk_rise  = sclk_s2 & ~sclk_s3;
  assign cs_rise    = cs_s2 & ~cs_s3;
  assign cs_low     = ~cs_s2;
  assign shift_next = {shift, data_s2};
  assign fsm_state  = state;

  // Frame FSM with registered outputs. A completing sclk rise takes priority
  // over a CS rise in the same cycle, so that word is accepted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      shift     <= '0;
      dataOut   <= '0;
      dataValid <= 1'b0;
      frameErr  <= 1'b0;
      bitCount  <= '0;
      busy      <= 1'b0;
    end else begin
      dataValid <= 1'b0;
      frameErr  <= 1'b0;
      case (state)
        IDLE: begin
          bitCount <= '0;
          busy     <= 1'b0;
          if (cs_low) begin
            state <= RECV;
            shift <= '0;
            busy  <= 1'b1;
          end
        end
        RECV: begin
          if (sclk_rise) begin
            if (bitCount == LAST_BIT) begin
              dataOut   <= shift_next;
              dataValid <= 1'b1;
              bitCount  <= '0;
              busy      <= 1'b0;
              state     <= cs_rise ? IDLE : HOLD;
            end else begin
              shift    <= shift_next[DATA_WIDTH-2:0];
              bitCount <= bitCount + CNT_WIDTH'(1);
            end
          end else if (cs_rise) begin
            frameErr <= (bitCount != '0);
            bitCount <= '0;
            busy     <= 1'b0;
            state    <= IDLE;
          end
        end
        HOLD: begin
          // Extra clocks beyond a full word are dropped silently.
          busy     <= 1'b0;
          bitCount <= '0;
          if (!cs_low) begin
            state <= IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          busy     <= 1'b0;
          bitCount <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_slave_rx.sv
// tb_spi_slave_rx: directed bench for spi_slave_rx. A frame-level model
// (queue of words the master completed, count of aborted frames) is checked
// every cycle against the strobes and dataOut.
module tb_spi_slave_rx;

  localparam int W  = 16;
  localparam int CW = 5;

  logic          clk;
  logic          reset;
  logic          spi_CS;
  logic          spi_sclk;
  logic          spiData;
  logic [W-1:0]  dataOut;
  logic          dataValid;
  logic          frameErr;
  logic [CW-1:0] bitCount;
  logic          busy;
  logic [1:0]    fsm_state;

  int checks = 0;
  int errors = 0;

  // Model state
  logic [W-1:0] exp_q[$];
  int           err_pending = 0;
  logic [W-1:0] model_last  = '0;
  logic [W-1:0] acc         = '0;
  int           frame_bits  = 0;
  bit           cs_active   = 0;
  bit           run         = 0;
  logic         prev_dv     = 0;
  logic         prev_fe     = 0;

  spi_slave_rx #(.DATA_WIDTH(W), .CNT_WIDTH(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .spi_CS    (spi_CS),
    .spi_sclk  (spi_sclk),
    .spiData   (spiData),
    .dataOut   (dataOut),
    .dataValid (dataValid),
    .frameErr  (frameErr),
    .bitCount  (bitCount),
    .busy      (busy),
    .fsm_state (fsm_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: frame-level model against the strobes every cycle.
  always @(negedge clk) begin
    if (run) begin
      if (!reset) begin
        model_last = '0;
        check("rst_outputs", {dataOut, dataValid, frameErr, bitCount, busy}, '0);
      end
      if (dataValid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_dataValid", 1, 0);
        end else begin
          model_last = exp_q.pop_front();
        end
      end
      if (frameErr) begin
        if (err_pending == 0) check("unexpected_frameErr", 1, 0);
        else err_pending--;
      end
      check("dataOut_track", dataOut, model_last);
      check("strobe_exclusive", dataValid & frameErr, 0);
      check("strobe_width", (dataValid & prev_dv) | (frameErr & prev_fe), 0);
      prev_dv = dataValid;
      prev_fe = frameErr;
    end
  end

  // Driver tasks. All pin changes happen at the falling clk edge; sclk high
  // and low phases are 4 clk periods each.
  task automatic cs_start();
    spi_CS = 1'b0;
    cs_active = 1;
    frame_bits = 0;
    acc = '0;
    repeat (4) @(negedge clk);
    check("start_busy", busy, 1);
    check("start_bitCount", bitCount, 0);
  endtask

  task automatic cs_end();
    spi_CS = 1'b1;
    if (cs_active && frame_bits > 0 && frame_bits < W) err_pending++;
    cs_active = 0;
    frame_bits = 0;
    repeat (4) @(negedge clk);
    check("end_busy", busy, 0);
    check("end_bitCount", bitCount, 0);
    check("end_frameErr_seen", err_pending, 0);
  endtask

  task automatic send_bit(input logic b, input bit with_cs_rise);
    int exp_bc;
    spiData = b;
    repeat (4) @(negedge clk);
    spi_sclk = 1'b1;
    if (with_cs_rise) spi_CS = 1'b1;
    if (cs_active) begin
      frame_bits++;
      if (frame_bits <= W) acc = {acc[W-2:0], b};
      if (frame_bits == W) exp_q.push_back(acc);
    end
    if (with_cs_rise) begin
      cs_active = 0;
    end
    // Word completion is visible on the third falling edge after sclk rises.
    repeat (3) @(negedge clk);
    if (frame_bits == W) check("dv_latency", dataValid, 1);
    @(negedge clk);
    exp_bc = (cs_active && frame_bits < W) ? frame_bits : 0;
    check("bit_count", bitCount, exp_bc);
    check("busy", busy, (cs_active && frame_bits < W) ? 1 : 0);
    spi_sclk = 1'b0;
    if (with_cs_rise) frame_bits = 0;
  endtask

  task automatic send_word(input logic [31:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(w[i], 0);
  endtask

  task automatic full_frame(input logic [W-1:0] w);
    cs_start();
    send_word(32'(w), W);
    cs_end();
  endtask

  initial begin
    reset    = 1'b0;
    spi_CS   = 1'b1;
    spi_sclk = 1'b0;
    spiData  = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_dataOut", dataOut, 16'h0000);
    check("reset_dataValid", dataValid, 0);
    check("reset_frameErr", frameErr, 0);
    check("reset_bitCount", bitCount, 0);
    check("reset_busy", busy, 0);
    run = 1;
    #2 reset = 1'b1;
    repeat (3) @(negedge clk);

    // Basic frame
    full_frame(16'hA5C3);
    check("t1_dataOut", dataOut, 16'hA5C3);
    check("t1_frameErr", frameErr, 0);

    // Back-to-back frames with a 4-clk CS-high gap
    full_frame(16'h0001);
    check("t2a_dataOut", dataOut, 16'h0001);
    full_frame(16'hFFFF);
    check("t2b_dataOut", dataOut, 16'hFFFF);

    // Good frame then an aborted frame after 7 bits
    full_frame(16'h1234);
    cs_start();
    send_word(32'h55, 7);
    cs_end();
    check("t3_dataOut_kept", dataOut, 16'h1234);
    check("t3_state_idle", fsm_state, 0);

    // 20 clocks in one CS window: word then 4 dropped bits
    cs_start();
    send_word(32'hBEEF, W);
    send_word(32'hA, 4);
    cs_end();
    check("t4_dataOut", dataOut, 16'hBEEF);

    // Reset after 9 bits, then a full frame
    cs_start();
    send_word(32'h1F3, 9);
    @(negedge clk);
    #2 reset = 1'b0;
    spi_CS = 1'b1;
    cs_active = 0;
    frame_bits = 0;
    repeat (3) @(negedge clk);
    check("t5_rst_dataOut", dataOut, 16'h0000);
    check("t5_rst_busy", busy, 0);
    #2 reset = 1'b1;
    repeat (4) @(negedge clk);
    full_frame(16'h5A5A);
    check("t5_dataOut", dataOut, 16'h5A5A);

    // sclk toggling with CS high: nothing happens
    spi_CS = 1'b1;
    cs_active = 0;
    for (int i = 0; i < W; i++) send_bit(1'($urandom_range(0, 1)), 0);
    check("t6_dataOut_kept", dataOut, 16'h5A5A);
    check("t6_state_idle", fsm_state, 0);

    // Final sclk rise and CS rise in the same cycle: word accepted
    cs_start();
    send_word(32'h3C96 >> 1, W - 1);
    send_bit(1'b0, 1);
    repeat (4) @(negedge clk);
    check("t7_dataOut", dataOut, 16'h3C96);
    check("t7_no_err", err_pending, 0);
    check("t7_busy", busy, 0);

    // Drain: every expected word and error must have been observed
    repeat (6) @(negedge clk);
    check("final_exp_q_empty", exp_q.size(), 0);
    check("final_err_pending", err_pending, 0);
    run = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
